// File: rtl/ultrasonic_pkg.sv
// Shared constants for the ultrasonic burst array: mode encoding, FSM states
// and the power-up shadow register contents.
package ultrasonic_pkg;

    localparam logic MODE_CONTINUOUS = 1'b0;
    localparam logic MODE_SINGLE     = 1'b1;

    // ~40.24 kHz carrier at 40 MHz, 32-cycle burst, 575-cycle repetition
    localparam int unsigned DEF_HALF_PERIOD = 497;
    localparam int unsigned DEF_BURST_LEN   = 32;
    localparam int unsigned DEF_REP_PERIOD  = 575;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/us_carrier_div.sv
// Carrier divider: counts 0..HP-1 per half cycle, phase high in the first half.
// Ports: CLK_40/RST (sync, active-high), run (low holds the divider at the
// start of a high half), half_period (0 treated as 1), phase (registered
// carrier phase), cycle_end (combinational strobe on the last clock of a
// low half, i.e. the last clock of a carrier cycle).
module us_carrier_div #(
    parameter int unsigned DIV_W = 10
) (
    input  logic             CLK_40,
    input  logic             RST,
    input  logic             run,
    input  logic [DIV_W-1:0] half_period,
    output logic             phase,
    output logic             cycle_end
);

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [DIV_W-1:0] hp_eff;
    logic             half_end;

    // Next divider state
    always_comb begin
        hp_eff   = (half_period == '0) ? DIV_W'(1) : half_period;
        half_end = (div_q == (hp_eff - DIV_W'(1)));
        div_d    = div_q;
        phase_d  = phase_q;
        if (!run) begin
            div_d   = '0;
            phase_d = 1'b1;
        end else if (half_end) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end else begin
            div_d   = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK_40) begin
        if (RST) begin
            div_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign phase     = phase_q;
    assign cycle_end = half_end & ~phase_q;

endmodule

// File: rtl/ultrasonic_burst_array.sv
// Multi-channel ultrasonic burst generator: repeating periods of carrier
// cycles, each channel bursting BURST_LEN cycles at its own offset.
// Ports: CLK_40/RST (sync, active-high), ON/MODE/TRIG control, HALF_PERIOD,
// BURST_LEN, REP_PERIOD, CH_DELAY, CH_EN configuration (shadowed at run start
// and period wraps), PULSE_P/PULSE_N complementary drives, PERIOD_START and
// DONE strobes, BUSY run indicator. All outputs registered.
module ultrasonic_burst_array
    import ultrasonic_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DIV_W         = 10,
    parameter int unsigned CYC_W         = 10,
    parameter int unsigned INITIAL_DELAY = 0
) (
    input  logic                    CLK_40,
    input  logic                    RST,
    input  logic                    ON,
    input  logic                    MODE,
    input  logic                    TRIG,
    input  logic [DIV_W-1:0]        HALF_PERIOD,
    input  logic [CYC_W-1:0]        BURST_LEN,
    input  logic [CYC_W-1:0]        REP_PERIOD,
    input  logic [NUM_CH*CYC_W-1:0] CH_DELAY,
    input  logic [NUM_CH-1:0]       CH_EN,
    output logic [NUM_CH-1:0]       PULSE_P,
    output logic [NUM_CH-1:0]       PULSE_N,
    output logic                    PERIOD_START,
    output logic                    BUSY,
    output logic                    DONE
);

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        hp_q, hp_d;
    logic [CYC_W-1:0]        bl_q, bl_d;
    logic [CYC_W-1:0]        rp_q, rp_d;
    logic [NUM_CH*CYC_W-1:0] dly_q, dly_d;
    logic [NUM_CH-1:0]       en_q, en_d;
    logic                    mode_q, mode_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [NUM_CH-1:0]       pulse_p_q, pulse_p_d;
    logic [NUM_CH-1:0]       pulse_n_q, pulse_n_d;
    logic                    period_start_q, period_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    start, wrap, div_run, phase, cycle_end;
    logic [CYC_W-1:0]        rp_eff;
    logic [CYC_W:0]          cyc_ext, bl_ext, d_ext;
    logic [NUM_CH-1:0]       win;

    us_carrier_div #(.DIV_W(DIV_W)) u_div (
        .CLK_40      (CLK_40),
        .RST         (RST),
        .run         (div_run),
        .half_period (hp_q),
        .phase       (phase),
        .cycle_end   (cycle_end)
    );

    // Run start and period wrap events
    always_comb begin
        rp_eff = (rp_q == '0) ? CYC_W'(1) : rp_q;
        start  = (state_q == ST_IDLE) && ON && ((MODE == MODE_CONTINUOUS) || TRIG);
        wrap   = (state_q == ST_RUN) && cycle_end && (cyc_q >= (rp_eff - CYC_W'(1)));
    end

    // FSM state register
    always_ff @(posedge CLK_40) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; ON low wins over a simultaneous single-shot wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (!ON)                                state_d = ST_IDLE;
                else if (wrap && mode_q == MODE_SINGLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow reload and cycle counter
    always_comb begin
        hp_d   = hp_q;
        bl_d   = bl_q;
        rp_d   = rp_q;
        dly_d  = dly_q;
        en_d   = en_q;
        mode_d = mode_q;
        cyc_d  = cyc_q;
        if (start || wrap) begin
            hp_d   = HALF_PERIOD;
            bl_d   = BURST_LEN;
            rp_d   = REP_PERIOD;
            dly_d  = CH_DELAY;
            en_d   = CH_EN;
            mode_d = MODE;
        end
        if (start)                                  cyc_d = CYC_W'(INITIAL_DELAY);
        else if (wrap)                              cyc_d = '0;
        else if (state_q == ST_RUN && cycle_end)    cyc_d = cyc_q + CYC_W'(1);
    end

    // Channel windows at CYC_W+1 bits so delay + length cannot wrap
    always_comb begin
        cyc_ext = {1'b0, cyc_q};
        bl_ext  = {1'b0, bl_q};
        d_ext   = '0;
        win     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            d_ext  = {1'b0, dly_q[c*CYC_W +: CYC_W]};
            win[c] = (cyc_ext >= d_ext) && (cyc_ext < (d_ext + bl_ext));
        end
    end

    // FSM outputs; pulses only where the run continues through this edge
    always_comb begin
        div_run        = (state_q == ST_RUN) && (state_d == ST_RUN);
        pulse_p_d      = div_run ? (win & en_q & {NUM_CH{phase}}) : '0;
        pulse_n_d      = (state_d == ST_RUN) ? (en_d & ~pulse_p_d) : '0;
        period_start_d = (state_d == ST_RUN) && (start || wrap);
        busy_d         = (state_d == ST_RUN);
        done_d         = wrap && ON && (mode_q == MODE_SINGLE);
    end

    always_ff @(posedge CLK_40) begin
        if (RST) begin
            hp_q           <= DIV_W'(DEF_HALF_PERIOD);
            bl_q           <= CYC_W'(DEF_BURST_LEN);
            rp_q           <= CYC_W'(DEF_REP_PERIOD);
            dly_q          <= '0;
            en_q           <= '0;
            mode_q         <= MODE_CONTINUOUS;
            cyc_q          <= '0;
            pulse_p_q      <= '0;
            pulse_n_q      <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            hp_q           <= hp_d;
            bl_q           <= bl_d;
            rp_q           <= rp_d;
            dly_q          <= dly_d;
            en_q           <= en_d;
            mode_q         <= mode_d;
            cyc_q          <= cyc_d;
            pulse_p_q      <= pulse_p_d;
            pulse_n_q      <= pulse_n_d;
            period_start_q <= period_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign PULSE_P      = pulse_p_q;
    assign PULSE_N      = pulse_n_q;
    assign PERIOD_START = period_start_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_ultrasonic_burst_array.sv
// Bench for ultrasonic_burst_array: directed scenarios plus random segments,
// expected outputs per clock queued by a timing model, checked by a monitor.
module tb_ultrasonic_burst_array;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 10;
    localparam int unsigned CYC_W  = 10;

    logic                    CLK_40 = 1'b0;
    logic                    RST, ON, MODE, TRIG;
    logic [DIV_W-1:0]        HALF_PERIOD;
    logic [CYC_W-1:0]        BURST_LEN, REP_PERIOD;
    logic [NUM_CH*CYC_W-1:0] CH_DELAY;
    logic [NUM_CH-1:0]       CH_EN;
    logic [NUM_CH-1:0]       PULSE_P, PULSE_N;
    logic                    PERIOD_START, BUSY, DONE;

    ultrasonic_burst_array #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CYC_W(CYC_W), .INITIAL_DELAY(0)
    ) dut (
        .CLK_40(CLK_40), .RST(RST), .ON(ON), .MODE(MODE), .TRIG(TRIG),
        .HALF_PERIOD(HALF_PERIOD), .BURST_LEN(BURST_LEN), .REP_PERIOD(REP_PERIOD),
        .CH_DELAY(CH_DELAY), .CH_EN(CH_EN),
        .PULSE_P(PULSE_P), .PULSE_N(PULSE_N), .PERIOD_START(PERIOD_START),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK_40 = ~CLK_40;

    typedef struct packed {
        logic [NUM_CH-1:0] p;
        logic [NUM_CH-1:0] n;
        logic              ps;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: run position u = clocks since the current period began
    bit          m_run = 0;
    int          m_u, m_hp, m_rp, m_bl, m_mode;
    int          m_d[NUM_CH];
    logic [NUM_CH-1:0] m_en;

    task automatic load_cfg();
        m_hp   = (HALF_PERIOD == 0) ? 1 : int'(HALF_PERIOD);
        m_rp   = (REP_PERIOD == 0) ? 1 : int'(REP_PERIOD);
        m_bl   = int'(BURST_LEN);
        m_mode = int'(MODE);
        m_en   = CH_EN;
        for (int c = 0; c < NUM_CH; c++) m_d[c] = int'(CH_DELAY[c*CYC_W +: CYC_W]);
    endtask

    // Predict outputs after the coming edge from the inputs presented to it
    task automatic model_step();
        exp_t e;
        int   len, cyc;
        bit   ph;
        logic [NUM_CH-1:0] pb;
        e = '0;
        if (RST) begin
            m_run = 0;
        end else if (!m_run) begin
            if (ON && (MODE == 1'b0 || TRIG)) begin
                load_cfg();
                m_run = 1; m_u = 0;
                e.busy = 1; e.ps = 1; e.n = m_en;
            end
        end else begin
            len = 2 * m_hp;
            cyc = m_u / len;
            ph  = (m_u % len) < m_hp;
            pb  = '0;
            for (int c = 0; c < NUM_CH; c++)
                if (ph && m_en[c] && cyc >= m_d[c] && cyc < m_d[c] + m_bl) pb[c] = 1'b1;
            if (!ON) begin
                m_run = 0;
            end else if (m_u == m_rp * len - 1) begin
                if (m_mode == 1) begin
                    m_run = 0; e.done = 1;
                end else begin
                    load_cfg();
                    m_u = 0;
                    e.busy = 1; e.ps = 1; e.p = pb; e.n = m_en & ~pb;
                end
            end else begin
                m_u++;
                e.busy = 1; e.p = pb; e.n = m_en & ~pb;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge CLK_40);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK_40);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_p", int'(PULSE_P), int'(e.p));
                chk("pulse_n", int'(PULSE_N), int'(e.n));
                chk("period_start", int'(PERIOD_START), int'(e.ps));
                chk("busy", int'(BUSY), int'(e.busy));
                chk("done", int'(DONE), int'(e.done));
                chk("p_n_overlap", int'(PULSE_P & PULSE_N), 0);
            end
        end
    end

    task automatic set_cfg(input int hp, input int bl, input int rp,
                           input logic [NUM_CH*CYC_W-1:0] dly, input logic [NUM_CH-1:0] en);
        HALF_PERIOD = DIV_W'(hp);
        BURST_LEN   = CYC_W'(bl);
        REP_PERIOD  = CYC_W'(rp);
        CH_DELAY    = dly;
        CH_EN       = en;
    endtask

    task automatic rand_cfg();
        logic [NUM_CH*CYC_W-1:0] dly;
        for (int c = 0; c < NUM_CH; c++) dly[c*CYC_W +: CYC_W] = CYC_W'($urandom_range(0, 6));
        set_cfg($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 6),
                dly, NUM_CH'($urandom_range(0, 15)));
    endtask

    initial begin
        RST = 1'b1; ON = 1'b0; MODE = 1'b0; TRIG = 1'b0;
        set_cfg(4, 3, 5, '0, 4'b0001);
        tick(3);
        RST = 1'b0;
        tick(2);

        // Continuous, single channel, 40-clock periods
        ON = 1'b1;
        tick(90);
        ON = 1'b0;
        tick(2);

        // Staggered channel delays
        set_cfg(2, 2, 8, {10'd3, 10'd2, 10'd1, 10'd0}, 4'b1111);
        ON = 1'b1;
        tick(70);
        ON = 1'b0;
        tick(2);

        // Single shot, one-clock trigger, then ignored trigger while off
        set_cfg(2, 2, 4, '0, 4'b0011);
        MODE = 1'b1; ON = 1'b1; TRIG = 1'b1;
        tick(1);
        TRIG = 1'b0;
        tick(22);
        ON = 1'b0; TRIG = 1'b1;
        tick(4);
        // Held trigger restarts right after DONE
        ON = 1'b1;
        tick(40);
        TRIG = 1'b0; ON = 1'b0;
        tick(2);

        // ON dropped during the second pulse
        MODE = 1'b0;
        set_cfg(4, 3, 5, '0, 4'b0001);
        ON = 1'b1;
        tick(11);
        ON = 1'b0;
        tick(4);

        // BURST_LEN change mid-period takes effect at the wrap
        ON = 1'b1;
        tick(10);
        BURST_LEN = CYC_W'(1);
        tick(75);
        ON = 1'b0;
        tick(2);

        // Zero half-period and repetition clamp to one
        set_cfg(0, 1, 0, '0, 4'b0001);
        ON = 1'b1;
        tick(20);

        // Reset mid-burst overrides ON
        set_cfg(3, 4, 6, '0, 4'b0101);
        ON = 1'b0;
        tick(1);
        ON = 1'b1;
        tick(9);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(20);

        // Random segments
        for (int s = 0; s < 40; s++) begin
            rand_cfg();
            MODE = 1'($urandom_range(0, 1));
            ON   = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < int'($urandom_range(20, 80)); k++) begin
                TRIG = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 29) == 0) rand_cfg();
                if ($urandom_range(0, 59) == 0) ON = ~ON;
                if ($urandom_range(0, 19) == 0) MODE = ~MODE;
                RST = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            RST = 1'b0;
        end

        ON = 1'b0; TRIG = 1'b0;
        tick(3);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge CLK_40);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_burst_array.md
ULTRASONIC_BURST_ARRAY -- requirements
Module: ultrasonic_burst_array

Interface
REQ-001 Parameter NUM_CH, default 4: number of transmitter channels.
REQ-002 Parameter DIV_W, default 10: width of HALF_PERIOD.
REQ-003 Parameter CYC_W, default 10: width of BURST_LEN, REP_PERIOD and each channel delay.
REQ-004 Parameter INITIAL_DELAY, default 0: carrier-cycle count loaded into the cycle counter at each run start.
REQ-005 CLK_40  in  1  40 MHz clock; reset RST, synchronous, active-high; clock CLK_40.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 ON  in  1  enable; low forces idle.
REQ-008 MODE  in  1  0 = continuous repetition, 1 = single-shot.
REQ-009 TRIG  in  1  single-shot start request, level-sampled.
REQ-010 HALF_PERIOD  in  DIV_W  carrier half-period in CLK_40 cycles.
REQ-011 BURST_LEN  in  CYC_W  carrier cycles per burst.
REQ-012 REP_PERIOD  in  CYC_W  carrier cycles per repetition period.
REQ-013 CH_DELAY  in  NUM_CH*CYC_W  per-channel burst offset in carrier cycles; channel c uses slice [c*CYC_W +: CYC_W].
REQ-014 CH_EN  in  NUM_CH  per-channel enable mask.
REQ-015 PULSE_P  out  NUM_CH  positive drive per channel, registered.
REQ-016 PULSE_N  out  NUM_CH  negative drive per channel, registered.
REQ-017 PERIOD_START  out  1  one-clock strobe at the start of each repetition period.
REQ-018 BUSY  out  1  high in RUN.
REQ-019 DONE  out  1  one-clock strobe when a single-shot period completes.

Function
REQ-020 The FSM SHALL have two states: IDLE and RUN.
- IDLE->RUN on a clock edge where ON=1 and (MODE=0 or TRIG=1).
- RUN->IDLE on any edge where ON=0, with no DONE.
REQ-021 On the IDLE->RUN edge the block SHALL:
- latch HALF_PERIOD, BURST_LEN, REP_PERIOD, CH_DELAY, CH_EN and MODE into shadow registers;
- zero the divider;
- load the cycle counter with INITIAL_DELAY.
REQ-022 At each later period wrap the shadow registers SHALL reload, so input changes take effect only at period boundaries.
REQ-023 Carrier: divider counts 0..HP-1 and toggles carrier phase at HP-1; phase is high for the first half of each carrier cycle. HP = max(HALF_PERIOD, 1).
REQ-024 The cycle counter SHALL increment at the end of each carrier low half and wrap from RP-1 to 0. RP = max(REP_PERIOD, 1).
REQ-025 Channel c window SHALL be active when D_c <= cyc < D_c + BURST_LEN, computed at CYC_W+1 bits so there is no wrap; cycles beyond RP-1 are never reached, so such bursts truncate.
REQ-026 PULSE_P[c] SHALL equal carrier phase AND window AND CH_EN[c], registered one clock after the divider state.
REQ-027 PULSE_N[c] SHALL equal NOT PULSE_P[c] while in RUN with CH_EN[c]=1; otherwise it SHALL be 0.
REQ-028 Both outputs of a channel SHALL never be high together.
REQ-029 BURST_LEN=0 SHALL produce no pulses while period timing still runs.
REQ-030 PERIOD_START SHALL assert in the clock following the run-start edge and following every wrap to 0.
REQ-031 Single-shot wrap: on the wrap from RP-1 the FSM SHALL go to IDLE and assert DONE for one clock. TRIG held high restarts on the next edge.
REQ-032 Continuous mode SHALL repeat indefinitely while ON=1. A MODE change applies at the next wrap.
REQ-033 In IDLE: all PULSE_P and PULSE_N = 0, BUSY = 0, and TRIG is ignored while ON=0.

Reset
REQ-034 While RST=1 the block SHALL:
- force IDLE;
- clear all counters, PULSE_P, PULSE_N, PERIOD_START, BUSY and DONE;
- clear the shadow registers to package defaults.
REQ-035 RST mid-burst SHALL take effect at the next edge and override ON/TRIG. The first possible run start is the edge after RST deasserts.

Structure
REQ-036 Package ultrasonic_pkg SHALL hold:
- MODE_CONTINUOUS=0 and MODE_SINGLE=1;
- default HALF_PERIOD 497 (~40.24 kHz at 40 MHz);
- default BURST_LEN 32 and REP_PERIOD 575.
REQ-037 The divider and phase toggle SHALL be one sub-module, us_carrier_div, with outputs phase and cycle_end strobe. The FSM, cycle counter and channel windows SHALL stay in the top module.

Verification
REQ-038 Test 1: HP=4, BURST_LEN=3, RP=5, CH_DELAY=0, CH_EN=0001, MODE=0, ON rises -> ch0 shows 3 pulses, each 4 clocks high / 4 low, then 16 clocks low; PERIOD_START every 40 clocks; PULSE_N = ~PULSE_P.
REQ-039 Test 2: CH_DELAY = {3,2,1,0}, HP=2, BURST_LEN=2, RP=8 -> channel c first rises 4*c clocks after channel 0; each channel gives exactly 2 pulses per period.
REQ-040 Test 3: MODE=1, one-clock TRIG, RP=4, HP=2 -> BUSY high 16 clocks, DONE single pulse at the wrap, then IDLE with all outputs 0.
REQ-041 Test 4: ON dropped in the middle of the second pulse -> next edge: BUSY=0, all PULSE_P and PULSE_N = 0, no DONE.
REQ-042 Test 5: BURST_LEN changed 3->1 mid-period -> current period keeps 3 pulses; next period has 1.
REQ-043 Test 6: HALF_PERIOD=0, REP_PERIOD=0, BURST_LEN=1 -> treated as HP=1, RP=1; ch0 toggles every clock continuously with PERIOD_START every 2 clocks.
